rsa_block_packer: RTL and testbench
===================================

Name: rsa_block_packer

Overview:
- Upstream feeder for the modular-exponentiation stage.
- Accepts a plaintext byte stream over valid/ready and packs byte pairs big-endian into 16-bit message blocks.
- Range-checks each block against the active modulus (RSA requires m < n) and buffers blocks in a small FIFO.
- Presents blocks to the exponentiator over a valid/ready interface, with last and error tags.

Parameters:
- DEPTH, 4, FIFO depth in blocks; power of 2, at least 2.
- PAD_BYTE, 8'h00, low byte used when the stream ends on an odd byte.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  plaintext byte
- in_valid  input  1  byte valid
- in_last  input  1  byte is last of message; qualified by in_valid
- in_ready  output  1  packer accepts byte this cycle
- modulus  input  16  RSA modulus n; must be stable while a message is in flight
- blk_data  output  16  message block to exponentiator
- blk_last  output  1  block is last of message
- blk_err  output  1  block is out of range (value >= modulus, or modulus < 2)
- blk_valid  output  1  FIFO head valid
- blk_ready  input  1  exponentiator consumes head
- err_count  output  8  count of out-of-range blocks, saturating
- busy  output  1  high byte pending or FIFO non-empty

Behaviour:
- Handshake: transfer on in_valid && in_ready. Blocks pop on blk_valid && blk_ready.
- Assembler FSM: states EMPTY and HAVE_HI.
  - EMPTY, byte accepted, in_last=0: hi_reg <= in_data; go to HAVE_HI. No push.
  - EMPTY, byte accepted, in_last=1: push {in_data, PAD_BYTE} with last=1; stay in EMPTY.
  - HAVE_HI, byte accepted: push {hi_reg, in_data} with last=in_last; go to EMPTY.
- push_needed = (state==HAVE_HI) || in_last.
- in_ready = !push_needed || !full.
  - Combinational on state, in_last and full only; never depends on blk_ready.
  - A full FIFO with a simultaneous pop still deasserts in_ready.
- Range check at push time, against the modulus sampled that cycle:
  - err = (block >= modulus) || (modulus < 16'd2).
  - Erroneous blocks are still pushed, with blk_err=1.
  - err_count increments per erroneous push and saturates at 255.
- FIFO:
  - Entry is 18 bits: {err, last, data[15:0]}.
  - Registered count, and read/write pointers that wrap modulo DEPTH.
  - full = (count == DEPTH). blk_valid = (count != 0).
  - Simultaneous push and pop while non-empty leaves count unchanged; the head advances and the new entry is written.
- Latency: a block is visible on blk_data/blk_valid the cycle after the accepting edge of its final byte. There is no same-cycle pass-through.
- blk_data, blk_last and blk_err hold stable while blk_valid=1 && blk_ready=0.
- busy = (state==HAVE_HI) || (count != 0).
- Reset (async, any time, including mid-message):
  - state=EMPTY, hi_reg=0, count=0, pointers=0, err_count=0.
  - Outputs go to blk_valid=0, blk_data=0, blk_last=0, blk_err=0, busy=0.
  - in_ready=1 since push_needed=0 unless in_last is high, and full=0.
  - A pending high byte is discarded.
- A modulus change while busy=1 is a usage error. The check simply uses the current value; no detection is required.

Test Plan:
- Modulus 16'h3233. Bytes 12, 34 (last on 34), blk_ready=1 → one block 16'h1234, last=1, err=0, valid exactly 1 cycle after the second byte is accepted.
- Modulus 16'h3233. Bytes 41, 42, 43 (last on 43) → blocks 16'h4142 (last=0, err=1) then 16'h4300 (last=1, err=1); err_count=2.
- blk_ready=0, DEPTH=4. Stream 10 bytes → after 4 blocks, in_ready drops while in HAVE_HI; 9th byte accepted, 10th stalled. Raise blk_ready → blocks drain in order 0x0001..0x0004-style payload, then the stalled block.
- Simultaneous push/pop with FIFO full and non-full → count constant, order preserved, no loss or duplication.
- Assert rst after a single high byte 16'hAB is accepted → busy=0, FIFO empty. Next bytes 01, 02 (last) yield 16'h0102, no 16'hAB remnant.
- Modulus 16'h0001 → every block has err=1. Push 260 error blocks → err_count saturates at 8'hFF.

Source files
------------

// File: rtl/rsa_block_packer.sv
// Packs a plaintext byte stream into big-endian 16-bit RSA message blocks,
// tags each block against the active modulus, and queues it for the exponentiator.
module rsa_block_packer #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [15:0] modulus,
  output logic [15:0] blk_data,
  output logic        blk_last,
  output logic        blk_err,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {EMPTY, HAVE_HI} state_t;

  state_t          state_q;
  logic [7:0]      hi_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      err_count_q, err_count_d;
  logic [17:0]     mem_q [DEPTH];

  logic            full, push_needed, accept, push, pop;
  logic [15:0]     push_blk;
  logic            push_last, push_err;
  logic [17:0]     head;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // RSA needs m < n; a modulus below 2 leaves no valid message space at all.
  function automatic logic range_err(input logic [15:0] blk, input logic [15:0] n);
    return (blk >= n) || (n < 16'd2);
  endfunction

  always_comb begin
    full        = (count_q == DEPTH_C);
    push_needed = (state_q == HAVE_HI) || in_last;
    in_ready    = !push_needed || !full;
    accept      = in_valid && in_ready;
    push        = accept && push_needed;
    blk_valid   = (count_q != '0);
    pop         = blk_valid && blk_ready;
    push_blk    = (state_q == HAVE_HI) ? {hi_q, in_data} : {in_data, PAD_BYTE};
    push_last   = (state_q == HAVE_HI) ? in_last : 1'b1;
    push_err    = range_err(push_blk, modulus);

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    err_count_d = (push && push_err) ? sat_inc8(err_count_q) : err_count_q;

    head        = mem_q[rd_ptr_q];
    blk_data    = blk_valid ? head[15:0] : 16'h0000;
    blk_last    = blk_valid && head[16];
    blk_err     = blk_valid && head[17];
    err_count   = err_count_q;
    busy        = (state_q == HAVE_HI) || blk_valid;
  end

  // Byte-pair assembler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      hi_q    <= 8'h00;
    end else if (accept) begin
      case (state_q)
        EMPTY: begin
          if (!in_last) begin
            hi_q    <= in_data;
            state_q <= HAVE_HI;
          end
        end
        HAVE_HI: state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  // FIFO storage; stale entries are masked at the output by blk_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_err, push_last, push_blk};
  end

endmodule

// File: tb/tb_rsa_block_packer.sv
// Scoreboard bench for rsa_block_packer: expected blocks are queued by the
// stimulus and popped by a monitor whenever the DUT hands a block off.
module tb_rsa_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [15:0] modulus;
  logic [15:0] blk_data;
  logic        blk_last, blk_err, blk_valid, blk_ready;
  logic [7:0]  err_count;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q [$];

  rsa_block_packer #(.DEPTH(4), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .modulus(modulus),
    .blk_data(blk_data), .blk_last(blk_last), .blk_err(blk_err),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .err_count(err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_blk(input logic err, input logic last, input logic [15:0] d);
    exp_q.push_back({err, last, d});
  endtask

  // Monitor: every handoff must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && blk_valid && blk_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_block: got %0h expected none", {blk_err, blk_last, blk_data});
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({blk_err, blk_last, blk_data} !== e) begin
          failures++;
          $display("FAIL block: got err=%0b last=%0b data=%04h expected err=%0b last=%0b data=%04h",
                   blk_err, blk_last, blk_data, e[17], e[16], e[15:0]);
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((blk_valid || exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_blk_valid", blk_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    modulus = 16'h3233; blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_data", blk_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic pair, one-cycle latency
    blk_ready = 1'b1;
    expect_blk(1'b0, 1'b1, 16'h1234);
    send_byte(8'h12, 1'b0);
    check("lat_no_early_valid", blk_valid, 0);
    check("lat_busy_hi", busy, 1);
    send_byte(8'h34, 1'b1);
    check("lat_valid_next_cycle", blk_valid, 1);
    check("lat_data", blk_data, 16'h1234);
    wait_drain();

    // Odd length with padding, both out of range
    expect_blk(1'b1, 1'b0, 16'h4142);
    expect_blk(1'b1, 1'b1, 16'h4300);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b1);
    wait_drain();
    check("err_count_two", err_count, 2);

    // Backpressure: fill the FIFO, then stall the completing byte
    blk_ready = 1'b0;
    for (int i = 1; i <= 4; i++) expect_blk(1'b0, 1'b0, 16'(i));
    expect_blk(1'b0, 1'b1, 16'h0005);
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'h00, 1'b0);
      send_byte(8'(i), 1'b0);
    end
    send_byte(8'h00, 1'b0);
    check("full_in_ready_low", in_ready, 0);
    check("full_busy", busy, 1);
    in_data = 8'h05; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_in_ready_low", in_ready, 0);
    check("stall_head_hold", {blk_last, blk_data}, {1'b0, 16'h0001});
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready_low", in_ready, 0);
    wait_accept();
    wait_drain();

    // Concurrent push and pop with entries already queued
    blk_ready = 1'b0;
    expect_blk(1'b0, 1'b0, 16'h1111);
    expect_blk(1'b0, 1'b0, 16'h2222);
    expect_blk(1'b0, 1'b0, 16'h0303);
    expect_blk(1'b0, 1'b0, 16'h0404);
    expect_blk(1'b0, 1'b1, 16'h0505);
    send_byte(8'h11, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h22, 1'b0);
    blk_ready = 1'b1;
    send_byte(8'h03, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0); send_byte(8'h05, 1'b1);
    wait_drain();

    // Mid-message reset discards the pending high byte
    send_byte(8'hAB, 1'b0);
    check("pre_rst_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", blk_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_blk(1'b0, 1'b1, 16'h0102);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    wait_drain();

    // Degenerate modulus: every block errs, counter saturates
    modulus = 16'h0001;
    for (int i = 0; i < 260; i++) begin
      expect_blk(1'b1, 1'b1, 16'(i));
      send_byte(8'(i >> 8), 1'b0);
      send_byte(8'(i), 1'b1);
      if (i == 253) check("err_count_254", err_count, 254);
    end
    wait_drain();
    check("err_count_saturated", err_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
